light_level_controller: RTL and testbench

Brightness sequencer for the light-stand PWM path. Consumes the free-running 0..999 period counter, holds a four-level brightness state machine driven by button pulses, fades the duty value toward the selected level's target at one step per PWM period, and generates the registered PWM output. Sits between the debounced button logic and the LED driver pin; the period counter stays a separate block shared with other consumers.

---
 rtl/light_level_controller.sv | 94 +++++++++
 tb/tb_light_level_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/light_level_controller.sv
// Brightness sequencer: four-level button FSM, per-period duty fade toward the
// level target, and a registered PWM compare against the shared period counter.
module light_level_controller #(
    parameter int PERIOD_MAX = 999,
    parameter int LOW_DUTY   = 250,
    parameter int MID_DUTY   = 500,
    parameter int HIGH_DUTY  = 900,
    parameter int FADE_STEP  = 50
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_counter,
    input  logic       i_btn_next,
    input  logic       i_btn_off,
    output logic [1:0] o_level,
    output logic [9:0] o_duty,
    output logic       o_pwm,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOW  = 2'd1,
        MID  = 2'd2,
        HIGH = 2'd3
    } level_t;

    localparam logic [9:0]  LAST_CNT = 10'(PERIOD_MAX);
    localparam logic [10:0] STEP     = 11'(FADE_STEP);

    level_t     level_q, level_d;
    logic [9:0] target;
    logic [9:0] duty_q;

    // 11-bit arithmetic so the add cannot wrap and the subtract cannot underflow
    function automatic logic [9:0] fade_next(input logic [9:0] duty, input logic [9:0] tgt);
        logic [10:0] d, t, sum;
        d   = {1'b0, duty};
        t   = {1'b0, tgt};
        sum = d + STEP;
        if (d < t)
            fade_next = (sum > t) ? tgt : sum[9:0];
        else if (d > t)
            fade_next = ((d - t) > STEP) ? 10'(d - STEP) : tgt;
        else
            fade_next = duty;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            level_q <= OFF;
        else
            level_q <= level_d;
    end

    always_comb begin
        level_d = level_q;
        if (i_btn_off)
            level_d = OFF;
        else if (i_btn_next)
            level_d = level_t'(level_q + 2'd1);
    end

    always_comb begin
        target = '0;
        case (level_q)
            OFF:  target = '0;
            LOW:  target = 10'(LOW_DUTY);
            MID:  target = 10'(MID_DUTY);
            HIGH: target = 10'(HIGH_DUTY);
            default: target = '0;
        endcase
    end

    // duty only moves on the last clock of a period so a period never sees two values
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            duty_q <= '0;
        else if (i_counter == LAST_CNT)
            duty_q <= fade_next(duty_q, target);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_pwm <= 1'b0;
        else
            o_pwm <= (i_counter < duty_q);
    end

    assign o_level = level_q;
    assign o_duty  = duty_q;
    assign o_busy  = (duty_q != target);

endmodule

// File: tb/tb_light_level_controller.sv
// Scoreboard bench: stimulus pushes model expectations per cycle, a monitor pops and
// compares two instances (default parameters, and HIGH_DUTY=1000 / FADE_STEP=300).
module tb_light_level_controller;

    typedef struct {
        int lvl;
        int duty;
        int pwm;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] counter = '0;
    logic       btn_next = 1'b0;
    logic       btn_off = 1'b0;
    logic [1:0] level_a, level_b;
    logic [9:0] duty_a, duty_b;
    logic       pwm_a, pwm_b, busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;
    int cnt   = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_lvl[2]  = '{0, 0};
    int m_duty[2] = '{0, 0};
    int p_high[2] = '{900, 1000};
    int p_step[2] = '{50, 300};

    light_level_controller dut_a (
        .i_clk(clk), .i_reset(rst), .i_counter(counter),
        .i_btn_next(btn_next), .i_btn_off(btn_off),
        .o_level(level_a), .o_duty(duty_a), .o_pwm(pwm_a), .o_busy(busy_a)
    );

    light_level_controller #(.HIGH_DUTY(1000), .FADE_STEP(300)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_counter(counter),
        .i_btn_next(btn_next), .i_btn_off(btn_off),
        .o_level(level_b), .o_duty(duty_b), .o_pwm(pwm_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    function automatic int tgt(input int lvl, input int k);
        case (lvl)
            1: return 250;
            2: return 500;
            3: return p_high[k];
            default: return 0;
        endcase
    endfunction

    function automatic int fade(input int d, input int t, input int s);
        if (d < t) return (d + s < t) ? d + s : t;
        if (d > t) return (d - s > t) ? d - s : t;
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lvl[k]  = 0;
            m_duty[k] = 0;
        end
    endtask

    // drive one clock of inputs and push what each DUT must show after the next edge
    task automatic step(input bit nx, input bit of);
        exp_t e;
        @(negedge clk);
        btn_next = nx;
        btn_off  = of;
        counter  = 10'(cnt);
        for (int k = 0; k < 2; k++) begin
            int nl, nd;
            nl = of ? 0 : (nx ? (m_lvl[k] + 1) % 4 : m_lvl[k]);
            nd = (cnt == 999) ? fade(m_duty[k], tgt(m_lvl[k], k), p_step[k]) : m_duty[k];
            e.pwm  = (cnt < m_duty[k]) ? 1 : 0;
            e.lvl  = nl;
            e.duty = nd;
            e.busy = (nd != tgt(nl, k)) ? 1 : 0;
            m_lvl[k]  = nl;
            m_duty[k] = nd;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        cnt = (cnt == 999) ? 0 : cnt + 1;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " level_a"}, int'(level_a), 0);
        chk({tag, " duty_a"},  int'(duty_a),  0);
        chk({tag, " pwm_a"},   int'(pwm_a),   0);
        chk({tag, " busy_a"},  int'(busy_a),  0);
        chk({tag, " level_b"}, int'(level_b), 0);
        chk({tag, " duty_b"},  int'(duty_b),  0);
        chk({tag, " pwm_b"},   int'(pwm_b),   0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("level_a", int'(level_a), e.lvl);
            chk("duty_a",  int'(duty_a),  e.duty);
            chk("pwm_a",   int'(pwm_a),   e.pwm);
            chk("busy_a",  int'(busy_a),  e.busy);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("level_b", int'(level_b), e.lvl);
            chk("duty_b",  int'(duty_b),  e.duty);
            chk("pwm_b",   int'(pwm_b),   e.pwm);
            chk("busy_b",  int'(busy_b),  e.busy);
        end
    end

    initial begin
        int budget;
        int r;

        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // idle, then one level up and let LOW settle
        run(3000);
        step(1'b1, 1'b0);
        run(6000);

        // LOW -> MID -> HIGH on back-to-back pulses, then wrap to OFF
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(14000);
        step(1'b1, 1'b0);
        run(19000);

        // climb toward HIGH, then next+off together once duty reaches 400
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        budget = 12000;
        while (m_duty[0] != 400 && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        if (budget == 0) chk("wait duty 400", m_duty[0], 400);
        step(1'b1, 1'b1);
        run(2100);

        repeat (5000) begin
            r = $urandom_range(0, 299);
            step(r == 0 || r == 2, r == 1 || r == 2);
        end

        // settle at MID, then assert reset mid-period while the PWM is high
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        budget = 25000;
        while (!(m_duty[0] == 500 && m_duty[1] == 500 && cnt == 500) && budget > 0) begin
            step(1'b0, 1'b0);
            budget--;
        end
        if (budget == 0) chk("wait duty 500", m_duty[0], 500);
        @(negedge clk);
        chk("pre-reset pwm_a", int'(pwm_a), 1);
        btn_next = 1'b0;
        btn_off  = 1'b0;
        counter  = 10'(cnt);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cnt = (cnt + 2) % 1000;

        run(5);
        step(1'b1, 1'b0);
        run(1500);

        @(posedge clk);
        #2;
        chk("queue drained a", q0.size(), 0);
        chk("queue drained b", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
